// File: rtl/controle_posse_if.sv
// Operator/shot-clock signal bundle for controle_posse.
//   btn_posse, btn_falta, btn_rebote, btn_run : active-low buttons (async)
//   contagem_in, buzzer_in                    : shot-clock readback (slow domain)
//   cmd_24, cmd_14, run_out                   : commands to the shot-clock counter
//   posse, violacao, estado                   : status for display/debug
// slave modport is the controller side; master is the driver side.
interface controle_posse_if;
   logic       btn_posse;
   logic       btn_falta;
   logic       btn_rebote;
   logic       btn_run;
   logic [4:0] contagem_in;
   logic       buzzer_in;
   logic       cmd_24;
   logic       cmd_14;
   logic       run_out;
   logic       posse;
   logic       violacao;
   logic [1:0] estado;

   modport slave (
      input  btn_posse, btn_falta, btn_rebote, btn_run, contagem_in, buzzer_in,
      output cmd_24, cmd_14, run_out, posse, violacao, estado
   );

   modport master (
      output btn_posse, btn_falta, btn_rebote, btn_run, contagem_in, buzzer_in,
      input  cmd_24, cmd_14, run_out, posse, violacao, estado
   );
endinterface

// File: rtl/controle_posse.sv
// Possession and shot-clock command controller.
// Turns debounced operator buttons and the shot-clock buzzer into reload
// (24/14), run and stop commands, tracks possession and latches violations.
// Ports:
//   clock_in : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : controle_posse_if.slave (buttons, readback, commands, status)
// Parameters: DEBOUNCE (stable cycles per button), HOLD (reload pulse cycles).
// Build option: CONTROLE_REBOTE14_EN selects the 14 s offensive-rebound rule;
// without it a rebound always reloads 24.
//
// state    | meaning
// PARADO   | shot clock stopped
// CORRENDO | shot clock running
// RECARGA  | reload command held for HOLD cycles, events ignored
// VIOLACAO | buzzer expired while running; waits for possession change
module controle_posse #(
   parameter int DEBOUNCE = 50000,
   parameter int HOLD     = 50000000
) (
   input  logic            clock_in,
   input  logic            reset_n,
   controle_posse_if.slave bus
);
   localparam int DB_W   = $clog2(DEBOUNCE + 1);
   localparam int HOLD_W = $clog2(HOLD + 1);

   typedef enum logic [1:0] {
      PARADO   = 2'd0,
      CORRENDO = 2'd1,
      RECARGA  = 2'd2,
      VIOLACAO = 2'd3
   } state_t;

   // bit order: 0 posse, 1 falta, 2 rebote, 3 run (also the priority order)
   logic [3:0]      btn_raw;
   logic [3:0]      btn_s1_q, btn_s2_q;
   logic [3:0]      deb_q, deb_d, deb_dly_q;
   logic [DB_W-1:0] db_cnt_q [4];
   logic [DB_W-1:0] db_cnt_d [4];
   logic [3:0]      press;
   logic            buz_s1_q, buz_s2_q, buz_s3_q, buz_ev;
   logic [4:0]      cont_s1_q, cont_s2_q;
   logic            cont_lt14;

   state_t          state_q, state_d, ret_q, ret_d;
   logic            sel14_q, sel14_d;
   logic            posse_q, posse_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic            reload24, reload14;

   assign btn_raw = {bus.btn_run, bus.btn_rebote, bus.btn_falta, bus.btn_posse};

   // Counter only advances while the synchronized level disagrees with the
   // debounced level; any return to agreement clears it.
   always_comb begin
      deb_d = deb_q;
      for (int i = 0; i < 4; i++) begin
         db_cnt_d[i] = '0;
         if (btn_s2_q[i] != deb_q[i]) begin
            if (db_cnt_q[i] == DB_W'(DEBOUNCE - 1)) deb_d[i] = btn_s2_q[i];
            else db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
         end
      end
   end

   assign press     = deb_dly_q & ~deb_q;
   assign buz_ev    = buz_s2_q & ~buz_s3_q;
   assign cont_lt14 = cont_s2_q < 5'd14;

   always_comb begin
      state_d    = state_q;
      ret_d      = ret_q;
      sel14_d    = sel14_q;
      posse_d    = posse_q;
      hold_cnt_d = '0;
      reload24   = 1'b0;
      reload14   = 1'b0;
      case (state_q)
         PARADO, CORRENDO: begin
            if (press[0]) begin
               posse_d  = ~posse_q;
               reload24 = 1'b1;
            end else if (press[1]) begin
               reload14 = cont_lt14;
            end else if (press[2]) begin
`ifdef CONTROLE_REBOTE14_EN
               reload14 = cont_lt14;
`else
               reload24 = 1'b1;
`endif
            end else if (press[3]) begin
               state_d = (state_q == PARADO) ? CORRENDO : PARADO;
            end else if (buz_ev && state_q == CORRENDO) begin
               state_d = VIOLACAO;
            end
            if (reload24 || reload14) begin
               ret_d   = state_q;
               sel14_d = reload14;
               state_d = RECARGA;
            end
         end
         RECARGA: begin
            if (hold_cnt_q == HOLD_W'(HOLD - 1)) state_d = ret_q;
            else hold_cnt_d = hold_cnt_q + HOLD_W'(1);
         end
         VIOLACAO: begin
            if (press[0]) begin
               posse_d = ~posse_q;
               ret_d   = PARADO;
               sel14_d = 1'b0;
               state_d = RECARGA;
            end
         end
         default: state_d = PARADO;
      endcase
   end

   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         btn_s1_q   <= '1;
         btn_s2_q   <= '1;
         deb_q      <= '1;
         deb_dly_q  <= '1;
         db_cnt_q   <= '{default: '0};
         buz_s1_q   <= 1'b0;
         buz_s2_q   <= 1'b0;
         buz_s3_q   <= 1'b0;
         cont_s1_q  <= '0;
         cont_s2_q  <= '0;
         state_q    <= PARADO;
         ret_q      <= PARADO;
         sel14_q    <= 1'b0;
         posse_q    <= 1'b0;
         hold_cnt_q <= '0;
      end else begin
         btn_s1_q   <= btn_raw;
         btn_s2_q   <= btn_s1_q;
         deb_q      <= deb_d;
         deb_dly_q  <= deb_q;
         db_cnt_q   <= db_cnt_d;
         buz_s1_q   <= bus.buzzer_in;
         buz_s2_q   <= buz_s1_q;
         buz_s3_q   <= buz_s2_q;
         cont_s1_q  <= bus.contagem_in;
         cont_s2_q  <= cont_s1_q;
         state_q    <= state_d;
         ret_q      <= ret_d;
         sel14_q    <= sel14_d;
         posse_q    <= posse_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

   // Commands are decoded from the state so a reset drops them immediately.
   // run_out in RECARGA follows the return state, i.e. its value on entry.
   assign bus.cmd_24   = (state_q == RECARGA) && !sel14_q;
   assign bus.cmd_14   = (state_q == RECARGA) &&  sel14_q;
   assign bus.run_out  = (state_q == CORRENDO) || (state_q == RECARGA && ret_q == CORRENDO);
   assign bus.violacao = (state_q == VIOLACAO);
   assign bus.posse    = posse_q;
   assign bus.estado   = state_q;
endmodule

// File: tb/tb_controle_posse.sv
module tb_controle_posse;
   localparam int DEB = 4;
   localparam int HLD = 8;
   localparam int B_POSSE = 0, B_FALTA = 1, B_REBOTE = 2, B_RUN = 3;

   logic clock_in = 1'b0;
   logic reset_n;
   always #5 clock_in = ~clock_in;

   controle_posse_if bus ();

   controle_posse #(.DEBOUNCE(DEB), .HOLD(HLD)) dut (
      .clock_in (clock_in),
      .reset_n  (reset_n),
      .bus      (bus)
   );

   int n_pass  = 0;
   int n_total = 0;

   // reference: mode 0 stopped, 1 running, 3 violation (reload phase is transient)
   int   m_mode;
   logic m_posse;

   logic [6:0] obs;
   assign obs = {bus.estado, bus.cmd_24, bus.cmd_14, bus.run_out, bus.violacao, bus.posse};

   function automatic logic [6:0] ev(int st, bit c24, bit c14, bit run, bit viol, bit p);
      return {2'(st), c24, c14, run, viol, p};
   endfunction

   // which reload (0 none, 24, 14) the scoreboard rules call for
   function automatic int exp_reload(int b, int c);
      if (m_mode == 3) return (b == B_POSSE) ? 24 : 0;
      case (b)
         B_POSSE:  return 24;
         B_FALTA:  return (c < 14) ? 14 : 0;
`ifdef CONTROLE_REBOTE14_EN
         B_REBOTE: return (c < 14) ? 14 : 0;
`else
         B_REBOTE: return 24;
`endif
         default:  return 0;
      endcase
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clock_in);
      #1;
   endtask

   task automatic set_btn(input int b, input logic v);
      case (b)
         B_POSSE:  bus.btn_posse  = v;
         B_FALTA:  bus.btn_falta  = v;
         B_REBOTE: bus.btn_rebote = v;
         default:  bus.btn_run    = v;
      endcase
   endtask

   // press one button and check the whole response cycle by cycle
   task automatic do_press(input int b, input int c, input string tag);
      int rl, old_mode, ret_mode;
      logic [6:0] e;
      bus.contagem_in = 5'(c);
      step(3);
      rl       = exp_reload(b, c);
      old_mode = m_mode;
      ret_mode = (old_mode == 3) ? 0 : old_mode;
      if (b == B_POSSE) m_posse = ~m_posse;
      if (rl != 0) m_mode = ret_mode;
      else if (b == B_RUN && old_mode != 3) m_mode = 1 - old_mode;
      set_btn(b, 1'b0);
      step(DEB + 2);
      e = ev(old_mode, 0, 0, old_mode == 1, old_mode == 3, (b == B_POSSE) ? ~m_posse : m_posse);
      n_total++;
      if (obs !== e) $display("FAIL %s_before_event: got %h want %h", tag, obs, e);
      else n_pass++;
      step(1);
      if (rl != 0) begin
         for (int i = 0; i < HLD; i++) begin
            if (i > 0) step(1);
            e = ev(2, rl == 24, rl == 14, ret_mode == 1, 0, m_posse);
            n_total++;
            if (obs !== e) $display("FAIL %s_reload_cycle%0d: got %h want %h", tag, i, obs, e);
            else n_pass++;
         end
         step(1);
      end
      e = ev(m_mode, 0, 0, m_mode == 1, m_mode == 3, m_posse);
      n_total++;
      if (obs !== e) $display("FAIL %s_after: got %h want %h", tag, obs, e);
      else n_pass++;
      set_btn(b, 1'b1);
      step(DEB + 4);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      bus.btn_posse = 1'b1; bus.btn_falta = 1'b1; bus.btn_rebote = 1'b1; bus.btn_run = 1'b1;
      bus.buzzer_in = 1'b0; bus.contagem_in = 5'd0;
      m_mode = 0; m_posse = 1'b0;
      step(3);
      n_total++;
      if (obs !== ev(0, 0, 0, 0, 0, 0)) $display("FAIL reset_held: got %h want %h", obs, ev(0, 0, 0, 0, 0, 0));
      else n_pass++;
      reset_n = 1'b1;
      step(3);
      n_total++;
      if (obs !== ev(0, 0, 0, 0, 0, 0)) $display("FAIL reset_released: got %h want %h", obs, ev(0, 0, 0, 0, 0, 0));
      else n_pass++;
   endtask

   task automatic test_run();
      do_press(B_RUN, 0, "run_start");
      set_btn(B_RUN, 1'b0);
      step(2);
      set_btn(B_RUN, 1'b1);
      step(12);
      n_total++;
      if (obs !== ev(1, 0, 0, 1, 0, m_posse)) $display("FAIL run_glitch: got %h want %h", obs, ev(1, 0, 0, 1, 0, m_posse));
      else n_pass++;
   endtask

   task automatic test_posse();
      do_press(B_POSSE, $urandom_range(0, 31), "posse");
   endtask

   task automatic test_falta();
      do_press(B_FALTA, 13, "falta13");
      do_press(B_FALTA, 14, "falta14");
      do_press(B_FALTA, 20, "falta20");
   endtask

   task automatic test_rebote();
      do_press(B_REBOTE, 20, "rebote20");
      do_press(B_REBOTE, 5,  "rebote5");
      do_press(B_REBOTE, 14, "rebote14");
   endtask

   task automatic test_buzzer();
      if (m_mode != 1) do_press(B_RUN, 0, "buz_setup");
      bus.buzzer_in = 1'b1;
      step(2);
      n_total++;
      if (obs !== ev(1, 0, 0, 1, 0, m_posse)) $display("FAIL buzzer_early: got %h want %h", obs, ev(1, 0, 0, 1, 0, m_posse));
      else n_pass++;
      step(1);
      m_mode = 3;
      n_total++;
      if (obs !== ev(3, 0, 0, 0, 1, m_posse)) $display("FAIL buzzer_violation: got %h want %h", obs, ev(3, 0, 0, 0, 1, m_posse));
      else n_pass++;
      do_press(B_FALTA, 3, "viol_falta");
      do_press(B_REBOTE, 3, "viol_rebote");
      do_press(B_RUN, 3, "viol_run");
      do_press(B_POSSE, 3, "viol_posse");
      bus.buzzer_in = 1'b0;
      step(4);
   endtask

   task automatic test_random();
      for (int k = 0; k < 12; k++)
         do_press($urandom_range(0, 3), $urandom_range(0, 31), "random");
   endtask

   task automatic test_simultaneous_reset();
      logic [6:0] e;
      bus.contagem_in = 5'd5;
      step(3);
      m_posse = ~m_posse;
      set_btn(B_POSSE, 1'b0);
      set_btn(B_FALTA, 1'b0);
      step(DEB + 3);
      e = ev(2, 1, 0, m_mode == 1, 0, m_posse);
      n_total++;
      if (obs !== e) $display("FAIL simul_entry: got %h want %h", obs, e);
      else n_pass++;
      step(3);
      n_total++;
      if (obs !== e) $display("FAIL simul_cycle4: got %h want %h", obs, e);
      else n_pass++;
      reset_n = 1'b0;
      #1;
      n_total++;
      if (obs !== ev(0, 0, 0, 0, 0, 0)) $display("FAIL reset_mid_reload: got %h want %h", obs, ev(0, 0, 0, 0, 0, 0));
      else n_pass++;
      set_btn(B_POSSE, 1'b1);
      set_btn(B_FALTA, 1'b1);
      m_mode = 0; m_posse = 1'b0;
      step(2);
      reset_n = 1'b1;
      step(HLD + DEB + 4);
      n_total++;
      if (obs !== ev(0, 0, 0, 0, 0, 0)) $display("FAIL after_reset_idle: got %h want %h", obs, ev(0, 0, 0, 0, 0, 0));
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_run();
      test_posse();
      test_falta();
      test_rebote();
      test_buzzer();
      test_random();
      test_simultaneous_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/controle_posse.md
# controle_posse

Possession and shot-clock command controller for the basketball scoreboard. It runs on the fast system clock and turns debounced operator buttons and game events into the reload, run and stop commands that the 24/14 s shot-clock counter consumes. It also reads back that counter's value and buzzer, latches shot-clock violations and tracks which team has possession.

## Interface
- DEBOUNCE, 50000: clock cycles a button input must be stable before its debounced level changes.
- HOLD, 50000000: clock cycles a reload command is held high. Must be at least one full period of the shot-clock's slow clock.
- clock_in  input  1  system clock; all logic on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- btn_posse  input  1  possession-change button, active-low, asynchronous.
- btn_falta  input  1  defensive-foul button, active-low, asynchronous.
- btn_rebote  input  1  offensive-rebound button, active-low, asynchronous.
- btn_run  input  1  start/stop toggle button, active-low, asynchronous.
- contagem_in  input  5  shot-clock count readback, slow-clock domain.
- buzzer_in  input  1  shot-clock buzzer readback, slow-clock domain.
- cmd_24  output  1  request reload of the shot clock to 24.
- cmd_14  output  1  request reload of the shot clock to 14.
- run_out  output  1  high lets the shot clock count. Its stop input is driven by ~run_out.
- posse  output  1  team in possession: 0 = home, 1 = away.
- violacao  output  1  sticky shot-clock violation flag.
- estado  output  2  current FSM state for the display/debug.

## Operation
- Every asynchronous input passes through a 2-flop synchronizer. contagem_in uses a 2-stage register, and compares use the second stage.
- Debounce: each button has its own counter that resets on any change of the synchronized level. When the counter reaches DEBOUNCE, the debounced level takes the new value.
- A press event is a one-cycle pulse on the debounced 1→0 edge.
- buzzer_in event: rising edge of the synchronized signal.
- Event priority when several occur in the same cycle: posse > falta > rebote > run. Lower-priority events are dropped.
- States and encodings:
  - PARADO=0: run_out=0.
  - CORRENDO=1: run_out=1.
  - RECARGA=2: run_out held at its value on entry.
  - VIOLACAO=3: run_out=0, violacao=1.
- PARADO and CORRENDO handle these events:
  - posse event: toggle posse, issue reload 24.
  - falta event: if contagem_in < 14, issue reload 14; otherwise no action.
  - rebote event: the rule is set under Configuration.
  - run event: PARADO→CORRENDO, or CORRENDO→PARADO.
  - buzzer_in event, in CORRENDO only: go to VIOLACAO.
- Issuing a reload stores the return state (PARADO or CORRENDO) and enters RECARGA with exactly one of cmd_24/cmd_14 high.
- RECARGA ignores all events, including buzzer_in. After HOLD cycles it drops the command and returns to the stored state.
- VIOLACAO responds only to a posse event: toggle posse, clear violacao, issue reload 24 with return state PARADO. All other events are ignored.
- cmd_24 and cmd_14 are never both high.

## Timing
- Reset values: estado=PARADO, posse=0, cmd_24=0, cmd_14=0, run_out=0, violacao=0. All debounced levels are 1 (released) and all counters are 0.
- Assertion of reset_n mid-RECARGA drops the command immediately.
- A button edge that stays stable produces its event DEBOUNCE+3 cycles after the edge: 2 sync cycles, DEBOUNCE counter cycles, 1 edge cycle.
- An event in cycle t gives estado=RECARGA and the command high from cycle t+1 through t+HOLD. At t+HOLD+1 the command is 0 and estado shows the return state.
- A run event in cycle t updates run_out at t+1.
- A buzzer_in rising edge reaches VIOLACAO 3 cycles after the input edge: 2 sync cycles plus 1.
- The HOLD counter is sized ceil(log2(HOLD+1)) bits, counts up from 0 and clears on leaving RECARGA. There is no wrap-around.
- contagem_in compare is unsigned 5-bit against 5'd14. The value 14 itself does not reload.

## Configuration
- CONTROLE_REBOTE14_EN defined: a rebote event issues reload 14 only when contagem_in < 14; otherwise there is no action. This is the FIBA rule.
- CONTROLE_REBOTE14_EN undefined: a rebote event always issues reload 24.

## Test plan
All scenarios run with DEBOUNCE=4 and HOLD=8.
- Reset, then btn_run pressed and held: run_out=1 and estado=1 seven cycles after the edge. A 2-cycle glitch on btn_run produces no event.
- In CORRENDO, posse pressed: posse toggles to 1, cmd_24 is high for exactly 8 cycles with cmd_14=0, and the block returns to CORRENDO with run_out=1 throughout.
- falta pressed with contagem_in=13: cmd_14 is high for 8 cycles. With contagem_in=14 or 20: no command and estado unchanged.
- rebote pressed with contagem_in=20: reload 24 when the macro is undefined, no command when the macro is defined. With contagem_in=5: cmd_14 when the macro is defined.
- In CORRENDO, buzzer_in rises: estado=3, violacao=1, run_out=0. falta, rebote and run are ignored. posse then toggles posse, gives violacao=0, holds cmd_24 for 8 cycles, and ends in PARADO.
- posse and falta events in the same cycle: only the posse reload is issued. reset_n asserted in the 4th cycle of RECARGA: cmd_24=0 at once, and all outputs return to their reset values.
